block_merge: RTL and testbench
==============================

BLOCK_MERGE -- requirements
Module: block_merge

Interface
REQ-001 Parameter BIT_WIDTH, default 8: bits per pixel.
REQ-002 Parameter DEPTH, default 2: tile buffer entries; legal range 2..8.
REQ-003 Parameter TILES_PER_FRAME, default 16: 6x6 tiles per frame; legal range 2..1024.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  block_in_0..3 carry a valid tile set.
REQ-007 in_ready  output  1  block accepts a tile set this cycle.
REQ-008 block_in_0..block_in_3  input  9*BIT_WIDTH each  denoised 3x3 blocks: top-left, top-right, bottom-left, bottom-right.
REQ-009 out_valid  output  1  pixel_out holds a valid 6x6 tile.
REQ-010 out_ready  input  1  downstream accepts the tile.
REQ-011 pixel_out  output  36*BIT_WIDTH  assembled 6x6 tile, row-major.
REQ-012 out_last  output  1  current output tile is last of frame.
REQ-013 tile_idx  output  ceil(log2(TILES_PER_FRAME))  index of current output tile within frame.

Function
REQ-014 Block pixel (r,c), r,c in 0..2, SHALL be read from bits [BIT_WIDTH*(3r+c) +: BIT_WIDTH] of each block_in_n.
REQ-015 Tile pixel (R,C), R,C in 0..5, SHALL be placed at pixel_out[BIT_WIDTH*(6R+C) +: BIT_WIDTH].
REQ-016 Mapping SHALL be: block_in_0 -> R 0..2, C 0..2; block_in_1 -> R 0..2, C 3..5; block_in_2 -> R 3..5, C 0..2; block_in_3 -> R 3..5, C 3..5; offsets added to (r,c).
REQ-017 Push SHALL occur when in_valid && in_ready; assembled tile written to FIFO tail.
REQ-018 Pop SHALL occur when out_valid && out_ready; head entry removed.
REQ-019 in_ready SHALL equal (count < DEPTH) && !rst; depends on registered state only, never on out_ready (no full-pop bypass).
REQ-020 out_valid SHALL equal (count != 0); pixel_out SHALL present head entry directly from registers.
REQ-021 Latency: tile pushed into empty buffer SHALL appear with out_valid=1 on the following cycle; no combinational in->out path.
REQ-022 Simultaneous push and pop with 0<count<DEPTH: count unchanged; both pointers advance.
REQ-023 Full (count==DEPTH): in_valid ignored; no overwrite. Empty: out_ready ignored; count never underflows.
REQ-024 Read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 pixel_out and tile_idx SHALL hold stable while out_valid && !out_ready.
REQ-026 tile_idx SHALL increment by 1 on each pop, wrapping TILES_PER_FRAME-1 -> 0.
REQ-027 out_last SHALL equal out_valid && (tile_idx == TILES_PER_FRAME-1).
REQ-028 Pixel data SHALL pass bit-exact; no arithmetic, clipping or reordering beyond REQ-016.

Reset
REQ-029 While rst=1 at a clock edge: count, pointers, tile_idx SHALL become 0; all storage entries SHALL become 0.
REQ-030 During and after reset: out_valid=0, out_last=0, pixel_out=0, tile_idx=0; in_ready=0 while rst=1, 1 the cycle after rst deasserts.
REQ-031 Reset mid-operation SHALL discard all buffered tiles; a push or pop coincident with rst SHALL have no effect.

Verification
REQ-032 Mapping: push block_in_n with pixel k = 16*n+k, out_ready=1 -> next cycle out_valid=1; pixel_out(0,0)=0x00, (0,3)=0x10, (3,0)=0x20, (5,5)=0x38.
REQ-033 Backpressure: out_ready=0, push 3 tiles at DEPTH=2 -> in_ready=0 after 2nd push, 3rd not accepted; pixel_out holds tile 1 unchanged.
REQ-034 Streaming: in_valid=1, out_ready=1 for 40 cycles -> one tile out per cycle after 1-cycle latency, order preserved, count constant at 1.
REQ-035 Frame wrap: 17 tiles at TILES_PER_FRAME=16 -> out_last=1 only on 16th tile (tile_idx=15); 17th tile tile_idx=0.
REQ-036 Reset mid-stream: 2 tiles buffered, assert rst 1 cycle -> out_valid=0, pixel_out=0, tile_idx=0; next pushed tile emerges with tile_idx=0.
REQ-037 Random in_valid/out_ready (50% each, 10k cycles) -> scoreboard match, no loss, duplication or overflow.

Source files
------------

// File: rtl/block_merge.sv
// Merges four denoised 3x3 blocks into one 6x6 tile and queues tiles in a
// small register FIFO, tracking each tile's position within the frame.
module block_merge #(
  parameter  int BIT_WIDTH       = 8,
  parameter  int DEPTH           = 2,
  parameter  int TILES_PER_FRAME = 16,
  localparam int IDX_W           = $clog2(TILES_PER_FRAME)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [9*BIT_WIDTH-1:0]    block_in_0,
  input  logic [9*BIT_WIDTH-1:0]    block_in_1,
  input  logic [9*BIT_WIDTH-1:0]    block_in_2,
  input  logic [9*BIT_WIDTH-1:0]    block_in_3,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [36*BIT_WIDTH-1:0]   pixel_out,
  output logic                      out_last,
  output logic [IDX_W-1:0]          tile_idx
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = 36 * BIT_WIDTH;

  logic [TW-1:0]                 mem_q [DEPTH];
  logic [PW-1:0]                 wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          push, pop;
  logic [TW-1:0]                 tile;
  logic [3:0][9*BIT_WIDTH-1:0]   blk;

  assign blk = {block_in_3, block_in_2, block_in_1, block_in_0};

  // Block n lands in quadrant (n/2, n%2); each quadrant is a 3x3 offset.
  for (genvar n = 0; n < 4; n++) begin : g_blk
    for (genvar r = 0; r < 3; r++) begin : g_row
      for (genvar c = 0; c < 3; c++) begin : g_col
        assign tile[BIT_WIDTH*(6*(r+3*(n/2)) + c+3*(n%2)) +: BIT_WIDTH] =
          blk[n][BIT_WIDTH*(3*r+c) +: BIT_WIDTH];
      end
    end
  end

  assign in_ready  = (count_q < CW'(DEPTH)) && !rst;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !rst;
  // Gate with out_valid so a drained buffer never shows stale pixels.
  assign pixel_out = out_valid ? mem_q[rptr_q] : '0;
  assign tile_idx  = idx_q;
  assign out_last  = out_valid && (idx_q == IDX_W'(TILES_PER_FRAME - 1));

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    idx_d   = idx_q;
    count_d = count_q;
    if (push) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
    if (pop) begin
      rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      idx_d  = (idx_q == IDX_W'(TILES_PER_FRAME - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) mem_q[wptr_q] <= tile;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_block_merge.sv
// Bench for block_merge: constant vector table, directed corner sequences,
// and a long random run checked against a queue-based reference model.
module tb_block_merge;
  localparam int BW    = 8;
  localparam int DEPTH = 2;
  localparam int TPF   = 16;
  localparam int TW    = 36 * BW;

  typedef logic [TW-1:0] tile_t;

  logic            clk = 1'b0;
  logic            rst, in_valid, out_ready;
  logic            in_ready, out_valid, out_last;
  logic [9*BW-1:0] b0, b1, b2, b3;
  tile_t           pixel_out;
  logic [3:0]      tile_idx;

  block_merge #(.BIT_WIDTH(BW), .DEPTH(DEPTH), .TILES_PER_FRAME(TPF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .block_in_0(b0), .block_in_1(b1), .block_in_2(b2), .block_in_3(b3),
    .out_valid(out_valid), .out_ready(out_ready), .pixel_out(pixel_out),
    .out_last(out_last), .tile_idx(tile_idx)
  );

  always #5 clk = ~clk;

  int     nvec = 0, nerr = 0;
  tile_t  q[$];
  int     midx = 0;
  logic [7:0] cur_base = 8'h00;

  // Expected tile: pixel (R,C) comes from block (R/3)*2+C/3, element 3*(R%3)+C%3,
  // and every block element k of block n is base+16n+k.
  function automatic tile_t mk_tile(logic [7:0] base);
    tile_t t = '0;
    for (int R = 0; R < 6; R++)
      for (int C = 0; C < 6; C++) begin
        int n = (R / 3) * 2 + (C / 3);
        int k = (R % 3) * 3 + (C % 3);
        t[BW*(6*R+C) +: BW] = base + 8'(16 * n + k);
      end
    return t;
  endfunction

  task automatic set_blocks(logic [7:0] base);
    logic [9*BW-1:0] v [4];
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 9; k++) v[n][BW*k +: BW] = base + 8'(16 * n + k);
    b0 = v[0]; b1 = v[1]; b2 = v[2]; b3 = v[3];
    cur_base = base;
  endtask

  task automatic chk(string nm, tile_t act, tile_t exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    chk("in_ready",  tile_t'(in_ready),  tile_t'(!rst && q.size() < DEPTH));
    chk("out_valid", tile_t'(out_valid), tile_t'(q.size() != 0));
    chk("pixel_out", pixel_out, (q.size() != 0) ? q[0] : tile_t'(0));
    chk("tile_idx",  tile_t'(tile_idx),  tile_t'(midx));
    chk("out_last",  tile_t'(out_last),  tile_t'(q.size() != 0 && midx == TPF - 1));
  endtask

  // One clock: decide handshakes from the model, advance it, compare after the edge.
  task automatic step();
    bit push, pop;
    push = in_valid && !rst && q.size() < DEPTH;
    pop  = out_ready && !rst && q.size() != 0;
    @(posedge clk);
    if (rst) begin
      q.delete();
      midx = 0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        midx = (midx + 1) % TPF;
      end
      if (push) q.push_back(mk_tile(cur_base));
    end
    #1;
    check_model();
  endtask

  typedef struct {
    bit rst, iv, ordy;
    logic [7:0] base;
    bit e_ready, e_valid;
    int e_idx;
    int e_head;   // expected head tile base, -1 means all-zero output
  } vec_t;

  vec_t vt [10];

  initial begin
    int last_at, pop_n, idx17;
    vt[0] = '{1, 1, 1, 8'h00, 0, 0, 0, -1};
    vt[1] = '{0, 1, 0, 8'h00, 1, 1, 0, 8'h00};
    vt[2] = '{0, 1, 0, 8'h40, 0, 1, 0, 8'h00};
    vt[3] = '{0, 1, 0, 8'h80, 0, 1, 0, 8'h00};
    vt[4] = '{0, 0, 1, 8'h80, 1, 1, 1, 8'h40};
    vt[5] = '{0, 1, 1, 8'h80, 1, 1, 2, 8'h80};
    vt[6] = '{0, 0, 1, 8'h80, 1, 0, 3, -1};
    vt[7] = '{0, 0, 1, 8'h80, 1, 0, 3, -1};
    vt[8] = '{1, 1, 1, 8'hC0, 0, 0, 0, -1};
    vt[9] = '{0, 0, 0, 8'hC0, 1, 0, 0, -1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_blocks(8'h00);
    step();

    for (int i = 0; i < 10; i++) begin
      rst = vt[i].rst; in_valid = vt[i].iv; out_ready = vt[i].ordy;
      set_blocks(vt[i].base);
      step();
      chk($sformatf("tbl%0d ready", i), tile_t'(in_ready), tile_t'(vt[i].e_ready));
      chk($sformatf("tbl%0d valid", i), tile_t'(out_valid), tile_t'(vt[i].e_valid));
      chk($sformatf("tbl%0d idx", i), tile_t'(tile_idx), tile_t'(vt[i].e_idx));
      chk($sformatf("tbl%0d pix", i), pixel_out,
          (vt[i].e_head < 0) ? tile_t'(0) : mk_tile(8'(vt[i].e_head)));
      if (i == 1) begin
        chk("map(0,0)", tile_t'(pixel_out[BW*0  +: BW]), tile_t'(8'h00));
        chk("map(0,3)", tile_t'(pixel_out[BW*3  +: BW]), tile_t'(8'h10));
        chk("map(3,0)", tile_t'(pixel_out[BW*18 +: BW]), tile_t'(8'h20));
        chk("map(5,5)", tile_t'(pixel_out[BW*35 +: BW]), tile_t'(8'h38));
      end
    end

    // Streaming: one in, one out per cycle, occupancy stays at one.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_blocks(8'(i * 3 + 1));
      step();
      if (i > 0) chk("stream count", tile_t'(q.size()), tile_t'(1));
    end
    in_valid = 1'b0;
    step();

    // Frame wrap: 17 tiles after a clean reset; last flag only on the 16th pop.
    rst = 1'b1; step(); rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    last_at = -1; pop_n = 0; idx17 = -1;
    for (int i = 0; i < 19; i++) begin
      if (i >= 17) in_valid = 1'b0;
      set_blocks(8'(i));
      if (out_valid && out_ready) begin
        pop_n++;
        if (out_last) last_at = (last_at < 0) ? pop_n : 999;
        if (pop_n == 17) idx17 = int'(tile_idx);
      end
      step();
    end
    chk("last on 16th", tile_t'(last_at), tile_t'(16));
    chk("17th idx",     tile_t'(idx17),   tile_t'(0));

    // Reset mid-stream with two tiles buffered.
    in_valid = 1'b1; out_ready = 1'b0;
    set_blocks(8'h55); step();
    set_blocks(8'h66); step();
    chk("pre-rst full", tile_t'(in_ready), tile_t'(0));
    rst = 1'b1; in_valid = 1'b0; step(); rst = 1'b0;
    chk("rst valid", tile_t'(out_valid), tile_t'(0));
    chk("rst pix",   pixel_out,          tile_t'(0));
    chk("rst idx",   tile_t'(tile_idx),  tile_t'(0));
    in_valid = 1'b1; set_blocks(8'h77); step(); in_valid = 1'b0;
    chk("post-rst tile", pixel_out,         mk_tile(8'h77));
    chk("post-rst idx",  tile_t'(tile_idx), tile_t'(0));
    out_ready = 1'b1; step();

    // Random handshakes against the model.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 499) == 0);
      set_blocks(8'($urandom));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
